// File: rtl/ext_pipe.sv
// Registered immediate extender for the ID/EX boundary: valid/ready stage with a
// 2-entry skid buffer, synchronous flush and a sticky reserved-opcode flag.
module ext_pipe #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int JT_W   = 26,
  parameter int SH_LO  = 6,
  parameter int SH_W   = 5,
  parameter int TAG_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [JT_W-1:0]   in_field,
  input  logic [2:0]        in_op,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              illegal_op
);

  localparam logic [2:0] OP_ZERO   = 3'b000;
  localparam logic [2:0] OP_SIGN   = 3'b001;
  localparam logic [2:0] OP_LUI    = 3'b010;
  localparam logic [2:0] OP_SHAMT  = 3'b011;
  localparam logic [2:0] OP_BRANCH = 3'b100;
  localparam logic [2:0] OP_JUMP   = 3'b101;

  // Reserved opcodes fall into the default arm and produce zero.
  function automatic logic [DATA_W-1:0] extend_f(
    input logic [JT_W-1:0]   field,
    input logic [2:0]        op,
    input logic [DATA_W-1:0] pc
  );
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] sx;
    logic [DATA_W-1:0] hi_mask;
    logic [DATA_W-1:0] res;
    imm     = field[IMM_W-1:0];
    sx      = DATA_W'(signed'(imm));
    hi_mask = ~((DATA_W'(1'b1) << (JT_W + 2)) - DATA_W'(1'b1));
    case (op)
      OP_ZERO:   res = DATA_W'(imm);
      OP_SIGN:   res = sx;
      OP_LUI:    res = DATA_W'(imm) << (DATA_W - IMM_W);
      OP_SHAMT:  res = DATA_W'(field[SH_LO +: SH_W]);
      OP_BRANCH: res = sx << 2;
      OP_JUMP:   res = (pc & hi_mask) | (DATA_W'(field) << 2);
      default:   res = {DATA_W{1'b0}};
    endcase
    return res;
  endfunction

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic [TAG_W-1:0]  m_tag_q,   m_tag_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;
  logic [TAG_W-1:0]  s_tag_q,   s_tag_d;
  logic              illegal_q, illegal_d;

  logic              accept_s;
  logic              pop_s;
  logic [DATA_W-1:0] ext_data_s;

  assign in_ready   = !s_valid_q;
  assign accept_s   = in_valid && in_ready;
  assign pop_s      = m_valid_q && out_ready;
  assign ext_data_s = extend_f(in_field, in_op, in_pc);

  assign out_valid  = m_valid_q;
  assign out_data   = m_data_q;
  assign out_tag    = m_tag_q;
  assign illegal_op = illegal_q;

  // Next-state for main/skid entries and the sticky illegal flag.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_tag_d   = m_tag_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    s_tag_d   = s_tag_q;
    illegal_d = illegal_q;

    if (flush) begin
      // Data fields hold; only the valid bits are dropped.
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else begin
      if (accept_s && (in_op[2:1] == 2'b11)) begin
        illegal_d = 1'b1;
      end else begin
        illegal_d = illegal_q;
      end

      if (!m_valid_q) begin
        if (accept_s) begin
          m_valid_d = 1'b1;
          m_data_d  = ext_data_s;
          m_tag_d   = in_tag;
        end else begin
          m_valid_d = 1'b0;
        end
      end else if (pop_s) begin
        if (s_valid_q) begin
          m_data_d  = s_data_q;
          m_tag_d   = s_tag_q;
          s_valid_d = 1'b0;
        end else if (accept_s) begin
          m_data_d  = ext_data_s;
          m_tag_d   = in_tag;
        end else begin
          m_valid_d = 1'b0;
        end
      end else begin
        if (accept_s) begin
          s_valid_d = 1'b1;
          s_data_d  = ext_data_s;
          s_tag_d   = in_tag;
        end else begin
          s_valid_d = s_valid_q;
        end
      end
    end
  end

  // State registers; everything including the sticky flag clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= {DATA_W{1'b0}};
      m_tag_q   <= {TAG_W{1'b0}};
      s_valid_q <= 1'b0;
      s_data_q  <= {DATA_W{1'b0}};
      s_tag_q   <= {TAG_W{1'b0}};
      illegal_q <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_tag_q   <= m_tag_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      s_tag_q   <= s_tag_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
// Scoreboard bench for ext_pipe: directed vectors push expectations, a negedge
// monitor pops and compares whatever the stage delivers.
module tb_ext_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [25:0] in_field;
  logic [2:0]  in_op;
  logic [31:0] in_pc;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_tag;
  logic        illegal_op;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          pops = 0;
  int          stall_cnt = 0;
  logic        skip_hold = 1'b0;
  logic        hold_pending = 1'b0;
  logic [31:0] hold_data;
  logic [7:0]  hold_tag;

  ext_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_field(in_field),
    .in_op(in_op), .in_pc(in_pc), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop-and-compare on every handshake, stability while stalled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_pending && !skip_hold) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", out_data, hold_data);
        check("stall_tag", 32'(out_tag), 32'(hold_tag));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got tag %0h data %0h expected nothing", out_tag, out_data);
        end else begin
          mon_e = sb.pop_front();
          check("sb_data", out_data, mon_e.data);
          check("sb_tag", 32'(out_tag), 32'(mon_e.tag));
          pops++;
        end
      end
      if (flush) sb.delete();
      hold_pending = out_valid && !out_ready && !flush;
      hold_data    = out_data;
      hold_tag     = out_tag;
    end
  end

  // Present one op; returns just after the edge on which it was accepted.
  task automatic send(input logic [2:0] op, input logic [25:0] field, input logic [31:0] pc,
                      input logic [7:0] tag, input logic [31:0] exp);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_field = field;
    in_pc    = pc;
    in_tag   = tag;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      stall_cnt++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck at %0d, required 1", in_ready);
    end else if (!flush) begin
      sb.push_back(exp_t'({exp, tag}));
    end
    @(posedge clk);
    #1;
  endtask

  // Single op with an explicit one-cycle latency check.
  task automatic one_shot(input string name, input logic [2:0] op, input logic [25:0] field,
                          input logic [31:0] pc, input logic [7:0] tag, input logic [31:0] exp);
    send(op, field, pc, tag, exp);
    in_valid = 1'b0;
    @(negedge clk);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_data"}, out_data, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pops0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_field = '0;
    in_op = 3'b000; in_pc = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_tag", 32'(out_tag), 32'h0);
    check("rst_illegal", 32'(illegal_op), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    one_shot("sign",   3'b001, 26'h0008001, 32'h0,        8'h01, 32'hFFFF8001);
    one_shot("lui",    3'b010, 26'h0001234, 32'h0,        8'h02, 32'h12340000);
    one_shot("zero",   3'b000, 26'h3FF8001, 32'h0,        8'h03, 32'h00008001);
    one_shot("shamt",  3'b011, 26'h0000D7F, 32'h0,        8'h04, 32'h00000015);
    one_shot("branch", 3'b100, 26'h000FFFF, 32'h0,        8'h05, 32'hFFFFFFFC);
    one_shot("jump",   3'b101, 26'h0000010, 32'hA0000000, 8'h06, 32'hA0000040);
    one_shot("jump_hi",3'b101, 26'h3FFFFFF, 32'hA5432107, 8'h07, 32'hAFFFFFFC);

    // Back-pressure: two entries fill, third waits upstream.
    out_ready = 1'b0;
    send(3'b000, 26'h0000011, 32'h0, 8'h11, 32'h00000011);
    send(3'b001, 26'h000F000, 32'h0, 8'h12, 32'hFFFFF000);
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    send(3'b010, 26'h000ABCD, 32'h0, 8'h13, 32'hABCD0000);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("bp_drained", 32'(sb.size()), 32'd0);

    // Flush with both entries full and an in-flight request.
    out_ready = 1'b0;
    send(3'b000, 26'h0000021, 32'h0, 8'h21, 32'h00000021);
    send(3'b000, 26'h0000022, 32'h0, 8'h22, 32'h00000022);
    in_valid = 1'b1; in_tag = 8'h23; in_field = 26'h23; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Flush coinciding with a pop: the pop still completes.
    pops0 = pops;
    send(3'b000, 26'h0000031, 32'h0, 8'h31, 32'h00000031);
    in_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flushpop_delivered", 32'(pops - pops0), 32'd1);
    check("flushpop_empty", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Reserved opcode: sticky flag, survives flush and legal traffic.
    one_shot("illegal", 3'b110, 26'h0001234, 32'h0, 8'h5A, 32'h0);
    check("illegal_tag", 32'(out_tag), 32'h5A);
    check("illegal_set", 32'(illegal_op), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("illegal_after_flush", 32'(illegal_op), 32'd1);
    @(posedge clk); #1;
    one_shot("legal_after", 3'b000, 26'h0000042, 32'h0, 8'h42, 32'h00000042);
    check("illegal_still", 32'(illegal_op), 32'd1);

    // Asynchronous reset while both entries are full.
    out_ready = 1'b0;
    send(3'b000, 26'h0000051, 32'h0, 8'h51, 32'h00000051);
    send(3'b000, 26'h0000052, 32'h0, 8'h52, 32'h00000052);
    in_valid = 1'b0;
    @(negedge clk);
    skip_hold = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_illegal", 32'(illegal_op), 32'd0);
    sb.delete();
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    skip_hold = 1'b0;

    // Sustained throughput after reset.
    out_ready = 1'b1;
    pops0     = pops;
    stall_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      send(3'b000, 26'(16'h0100 + i), 32'h0, 8'(8'h60 + i), 32'(16'h0100 + i));
    end
    in_valid = 1'b0;
    check("tput_no_stall", 32'(stall_cnt), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("tput_pops", 32'(pops - pops0), 32'd16);
    check("final_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
